// File: rtl/clint_timer.sv
// Machine timer block: 64-bit mtime with prescaler, 64-bit mtimecmp, and a
// small interrupt handshake FSM that presents the timer cause to the CSR file.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   IDLE       | no timer interrupt outstanding
//   PENDING    | compare hit, cause presented, waiting for trap_ack
//   IN_SERVICE | trap taken, waiting for mret before re-arming
module clint_timer #(
    parameter logic [31:0] ADDR_BASE = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        trap_ack,
    input  logic        mret,
    output logic [31:0] cause,
    output logic        irq_pending
);

    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        enable;
    logic [15:0] prescale;
    logic [15:0] tick_cnt;

    logic [31:0] offset;
    logic        mapped;
    logic [2:0]  word;
    logic        wr_time_lo;
    logic        wr_time_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        tick;

    // Offset relative to the window; addresses below the base wrap high and miss.
    assign offset = bus_addr - ADDR_BASE;
    assign mapped = (offset[1:0] == 2'b00) && (offset <= 32'h0000_0010);
    assign word   = offset[4:2];

    assign wr_time_lo = bus_wr && mapped && (word == 3'd0);
    assign wr_time_hi = bus_wr && mapped && (word == 3'd1);
    assign wr_cmp_lo  = bus_wr && mapped && (word == 3'd2);
    assign wr_cmp_hi  = bus_wr && mapped && (word == 3'd3);
    assign wr_ctrl    = bus_wr && mapped && (word == 3'd4);

    assign tick        = enable && (tick_cnt == prescale);
    assign irq_pending = enable && (mtime >= mtimecmp);

    always_comb begin
        bus_rdata = 32'h0;
        if (bus_rd && mapped) begin
            case (word)
                3'd0:    bus_rdata = mtime[31:0];
                3'd1:    bus_rdata = mtime[63:32];
                3'd2:    bus_rdata = mtimecmp[31:0];
                3'd3:    bus_rdata = mtimecmp[63:32];
                3'd4:    bus_rdata = {prescale, 15'h0, enable};
                default: bus_rdata = 32'h0;
            endcase
        end
    end

    // A bus write to either mtime half suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'h0;
        end else if (wr_time_lo) begin
            mtime[31:0] <= bus_wdata;
        end else if (wr_time_hi) begin
            mtime[63:32] <= bus_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= bus_wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= 1'b0;
            prescale <= 16'h0;
            tick_cnt <= 16'h0;
        end else if (wr_ctrl) begin
            enable   <= bus_wdata[0];
            prescale <= bus_wdata[31:16];
            tick_cnt <= 16'h0;
        end else if (tick) begin
            tick_cnt <= 16'h0;
        end else if (enable) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // cause is registered alongside the state so it is glitch-free at the CSR file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cause <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (irq_pending) begin
                        state <= PENDING;
                        cause <= CAUSE_MTI;
                    end else begin
                        cause <= 32'h0;
                    end
                end
                PENDING: begin
                    if (trap_ack) begin
                        state <= IN_SERVICE;
                        cause <= 32'h0;
                    end else if (!irq_pending) begin
                        state <= IDLE;
                        cause <= 32'h0;
                    end else begin
                        cause <= CAUSE_MTI;
                    end
                end
                IN_SERVICE: begin
                    cause <= 32'h0;
                    if (mret) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cause <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: a driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_clint_timer;

    localparam logic [31:0] BASE      = 32'h0200_0000;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam int PH_IDLE = 0;
    localparam int PH_PEND = 1;
    localparam int PH_SERV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        trap_ack;
    logic        mret;
    logic [31:0] cause;
    logic        irq_pending;

    clint_timer #(.ADDR_BASE(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .trap_ack    (trap_ack),
        .mret        (mret),
        .cause       (cause),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        irq;
        logic [31:0] cause;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [15:0] m_presc;
    int          m_cnt;
    int          m_phase;

    // Directed expectations written straight from the requirement text
    logic        ovr_rd_v    = 1'b0;
    logic [31:0] ovr_rd      = 32'h0;
    logic        ovr_cause_v = 1'b0;
    logic [31:0] ovr_cause   = 32'h0;

    function automatic int word_of(input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (a == BASE + 32'(4 * i)) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (word_of(a))
            0:       return m_time[31:0];
            1:       return m_time[63:32];
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {m_presc, 15'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_time  = 64'h0;
        m_cmp   = '1;
        m_en    = 1'b0;
        m_presc = 16'h0;
        m_cnt   = 0;
        m_phase = PH_IDLE;
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic ack, input logic mr, input logic rs);
        logic pend;
        logic tk;
        int   wsel;
        if (rs) begin
            model_reset();
            return;
        end
        pend = m_en && (m_time >= m_cmp);
        tk   = m_en && (m_cnt == int'(m_presc));
        wsel = w ? word_of(a) : -1;
        if (m_phase == PH_IDLE && pend) m_phase = PH_PEND;
        else if (m_phase == PH_PEND && ack) m_phase = PH_SERV;
        else if (m_phase == PH_PEND && !pend) m_phase = PH_IDLE;
        else if (m_phase == PH_SERV && mr) m_phase = PH_IDLE;
        if (wsel == 0) m_time[31:0] = d;
        else if (wsel == 1) m_time[63:32] = d;
        else if (tk) m_time = m_time + 64'd1;
        if (wsel == 2) m_cmp[31:0] = d;
        if (wsel == 3) m_cmp[63:32] = d;
        if (wsel == 4) begin
            m_en    = d[0];
            m_presc = d[31:16];
            m_cnt   = 0;
        end else if (tk) begin
            m_cnt = 0;
        end else if (m_en) begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, input logic mr, input logic rs);
        exp_t e;
        @(posedge clk);
        #2;
        rst       = rs;
        bus_wr    = w;
        bus_rd    = r;
        bus_addr  = a;
        bus_wdata = d;
        trap_ack  = ack;
        mret      = mr;
        e.rdata = r ? model_read(a) : 32'h0;
        e.irq   = m_en && (m_time >= m_cmp);
        e.cause = (m_phase == PH_PEND) ? CAUSE_MTI : 32'h0;
        if (ovr_rd_v) e.rdata = ovr_rd;
        if (ovr_cause_v) e.cause = ovr_cause;
        ovr_rd_v    = 1'b0;
        ovr_cause_v = 1'b0;
        e.cyc = 32'(cyc);
        cyc++;
        sb.push_back(e);
        model_step(w, a, d, ack, mr, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1, 0, a, d, 0, 0, 0);
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] v);
        ovr_rd_v = 1'b1;
        ovr_rd   = v;
        cycle(0, 1, a, 32'h0, 0, 0, 0);
    endtask

    task automatic exp_cause(input logic [31:0] v);
        ovr_cause_v = 1'b1;
        ovr_cause   = v;
    endtask

    task automatic do_reset();
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input logic [31:0] c);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("bus_rdata", bus_rdata, mon_e.rdata, mon_e.cyc);
            chk("irq_pending", {31'h0, irq_pending}, {31'h0, mon_e.irq}, mon_e.cyc);
            chk("cause", cause, mon_e.cause, mon_e.cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] ra;
    logic [31:0] rdv;
    int          k;

    initial begin
        rst = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 32'h0;
        bus_wdata = 32'h0; trap_ack = 1'b0; mret = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Free-running count, prescale 0
        do_reset();
        wr(BASE + 32'h10, 32'h0000_0001);
        idle(10);
        exp_cause(32'h0);
        rd_exp(BASE + 32'h00, 32'd10);

        // Prescale 3: one increment per 4 cycles
        do_reset();
        wr(BASE + 32'h10, 32'h0003_0001);
        idle(40);
        rd_exp(BASE + 32'h00, 32'd10);
        rd_exp(BASE + 32'h10, 32'h0003_0001);

        // Carry from low to high word
        do_reset();
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 32'h0000_0001);
        rd_exp(BASE + 32'h00, 32'hFFFF_FFFF);
        rd_exp(BASE + 32'h00, 32'h0);
        rd_exp(BASE + 32'h04, 32'h1);

        // Full 64-bit wrap
        do_reset();
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 32'h0000_0001);
        rd_exp(BASE + 32'h04, 32'hFFFF_FFFF);
        rd_exp(BASE + 32'h04, 32'h0);
        rd_exp(BASE + 32'h00, 32'h1);

        // Write to an mtime half while ticking: written half wins, other holds
        do_reset();
        wr(BASE + 32'h10, 32'h0000_0001);
        idle(3);
        wr(BASE + 32'h04, 32'h1234_5678);
        rd_exp(BASE + 32'h00, 32'd3);
        rd_exp(BASE + 32'h04, 32'h1234_5678);

        // Unmapped writes and reads
        do_reset();
        wr(BASE + 32'h14, 32'hDEAD_BEEF);
        wr(BASE + 32'h02, 32'hDEAD_BEEF);
        wr(BASE - 32'h04, 32'hDEAD_BEEF);
        rd_exp(BASE + 32'h14, 32'h0);
        rd_exp(BASE + 32'h01, 32'h0);
        rd_exp(BASE + 32'h00, 32'h0);
        rd_exp(BASE + 32'h08, 32'hFFFF_FFFF);
        rd_exp(BASE + 32'h10, 32'h0);

        // Compare at 5, trap, mret re-raise, then disarm by rewriting mtimecmp
        do_reset();
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h08, 32'd5);
        wr(BASE + 32'h10, 32'h0000_0001);
        idle(5);
        exp_cause(32'h0);
        idle(1);
        exp_cause(CAUSE_MTI);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 0);
        exp_cause(32'h0);
        idle(2);
        cycle(0, 0, 32'h0, 32'h0, 0, 1, 0);
        exp_cause(32'h0);
        idle(1);
        exp_cause(CAUSE_MTI);
        idle(1);
        wr(BASE + 32'h0C, 32'hFFFF_FFFF);
        idle(1);
        exp_cause(32'h0);
        idle(3);

        // trap_ack ignored in service; mret beats trap_ack there; reset aborts
        do_reset();
        wr(BASE + 32'h0C, 32'h0);
        wr(BASE + 32'h08, 32'd3);
        wr(BASE + 32'h10, 32'h0000_0001);
        idle(6);
        cycle(0, 0, 32'h0, 32'h0, 1, 1, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 1, 0);
        idle(3);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 0);
        idle(2);
        do_reset();
        exp_cause(32'h0);
        rd_exp(BASE + 32'h0C, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 32'h0000_0001);
        idle(30);
        exp_cause(32'h0);
        rd_exp(BASE + 32'h08, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            k = int'($urandom_range(0, 7));
            case (k)
                0, 1, 2, 3, 4: ra = BASE + 32'(4 * k);
                5:             ra = BASE + 32'h14;
                6:             ra = BASE + 32'($urandom_range(1, 3));
                default:       ra = BASE - 32'h04;
            endcase
            case (k)
                0: rdv = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
                1: rdv = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 2));
                2: rdv = m_time[31:0] + 32'($urandom_range(0, 24));
                3: rdv = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : m_time[63:32];
                4: rdv = {16'($urandom_range(0, 3)), 15'($urandom), 1'($urandom_range(0, 4) != 0)};
                default: rdv = $urandom;
            endcase
            cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), ra, rdv,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 199) == 0));
        end
        idle(2);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
